// File: rtl/seg_scan_ctrl.sv
// Multiplexed DIGITS-wide hex 7-segment scanner with tear-free loading,
// decimal points, per-digit blink, leading-zero blanking and PWM brightness.
module seg_scan_ctrl #(
   parameter int DIGITS       = 4,
   parameter int DIV          = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blink_mask,
   input  logic                  load,
   input  logic                  lz_blank,
   input  logic [2:0]            brightness,
   output logic [7:1]            cathodes,
   output logic                  dp_n,
   output logic [DIGITS-1:0]     AN,
   output logic                  frame_done
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
   localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);
   localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);

   function automatic logic [7:1] hex_font(input logic [3:0] n);
      case (n)
         4'h0: hex_font = 7'b0000001;
         4'h1: hex_font = 7'b1001111;
         4'h2: hex_font = 7'b0010010;
         4'h3: hex_font = 7'b0000110;
         4'h4: hex_font = 7'b1001100;
         4'h5: hex_font = 7'b0100100;
         4'h6: hex_font = 7'b0100000;
         4'h7: hex_font = 7'b0001111;
         4'h8: hex_font = 7'b0000000;
         4'h9: hex_font = 7'b0000100;
         4'hA: hex_font = 7'b0001000;
         4'hB: hex_font = 7'b1100000;
         4'hC: hex_font = 7'b1110010;
         4'hD: hex_font = 7'b1000010;
         4'hE: hex_font = 7'b0110000;
         default: hex_font = 7'b0111000;
      endcase
   endfunction

   logic [PW-1:0]         pcnt_q, pcnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [FW-1:0]         fcnt_q, fcnt_d;
   logic                  blink_q, blink_d;
   logic                  pend_q, pend_d;
   logic [4*DIGITS-1:0]   pend_val_q, pend_val_d, sh_val_q, sh_val_d;
   logic [DIGITS-1:0]     pend_dp_q, pend_dp_d, sh_dp_q, sh_dp_d;
   logic [DIGITS-1:0]     pend_bm_q, pend_bm_d, sh_bm_q, sh_bm_d;
   logic [DIGITS-1:0]     an_q, an_d;
   logic [7:1]            cath_q, cath_d;
   logic                  dpn_q, dpn_d;
   logic                  fd_q, fd_d;

   logic                  slot_end, wrap, lit, show, above, zero_i;
   logic [3:0]            nib;
   logic                  dsel, bsel, lzsel;

   always_comb begin
      pcnt_d     = pcnt_q;
      idx_d      = idx_q;
      fcnt_d     = fcnt_q;
      blink_d    = blink_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
      pend_bm_d  = pend_bm_q;
      sh_val_d   = sh_val_q;
      sh_dp_d    = sh_dp_q;
      sh_bm_d    = sh_bm_q;

      slot_end = (pcnt_q == PMAX);
      wrap     = slot_end && (idx_q == IMAX);
      pcnt_d   = slot_end ? '0 : pcnt_q + 1'b1;
      if (slot_end) idx_d = wrap ? '0 : idx_q + 1'b1;

      if (wrap) begin
         fcnt_d = (fcnt_q == FMAX) ? '0 : fcnt_q + 1'b1;
         if (fcnt_q == FMAX) blink_d = ~blink_q;
         // Commit the older pending data; a load in this same cycle re-arms pend below.
         if (pend_q) begin
            sh_val_d = pend_val_q;
            sh_dp_d  = pend_dp_q;
            sh_bm_d  = pend_bm_q;
            pend_d   = 1'b0;
         end
      end
      if (load) begin
         pend_val_d = value;
         pend_dp_d  = dp;
         pend_bm_d  = blink_mask;
         pend_d     = 1'b1;
      end
      fd_d = wrap;

      // Leading-zero chain runs from the top digit down; digit 0 always shows.
      nib   = '0;
      dsel  = 1'b0;
      bsel  = 1'b0;
      lzsel = 1'b0;
      above = 1'b1;
      zero_i = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_i = lz_blank && (sh_val_q[4*i +: 4] == 4'h0) && !sh_dp_q[i] && above;
         above  = zero_i;
         if (idx_q == IW'(i)) begin
            nib   = sh_val_q[4*i +: 4];
            dsel  = sh_dp_q[i];
            bsel  = sh_bm_q[i];
            lzsel = zero_i && (i != 0);
         end
      end

      lit  = (32'(pcnt_q) * 32'd8) < ((32'(brightness) + 32'd1) * 32'(DIV));
      show = lit && !(bsel && blink_q) && !lzsel;

      an_d   = '1;
      cath_d = 7'b1111111;
      dpn_d  = 1'b1;
      if (show) begin
         an_d   = ~(DIGITS'(1) << idx_q);
         cath_d = hex_font(nib);
         dpn_d  = ~dsel;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt_q     <= '0;
         idx_q      <= '0;
         fcnt_q     <= '0;
         blink_q    <= 1'b0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         pend_dp_q  <= '0;
         pend_bm_q  <= '0;
         sh_val_q   <= '0;
         sh_dp_q    <= '0;
         sh_bm_q    <= '0;
         an_q       <= '1;
         cath_q     <= 7'b1111111;
         dpn_q      <= 1'b1;
         fd_q       <= 1'b0;
      end else begin
         pcnt_q     <= pcnt_d;
         idx_q      <= idx_d;
         fcnt_q     <= fcnt_d;
         blink_q    <= blink_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         pend_dp_q  <= pend_dp_d;
         pend_bm_q  <= pend_bm_d;
         sh_val_q   <= sh_val_d;
         sh_dp_q    <= sh_dp_d;
         sh_bm_q    <= sh_bm_d;
         an_q       <= an_d;
         cath_q     <= cath_d;
         dpn_q      <= dpn_d;
         fd_q       <= fd_d;
      end
   end

   assign AN         = an_q;
   assign cathodes   = cath_q;
   assign dp_n       = dpn_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random loads, checked
// every cycle against a time-indexed behavioural model of the scanner.
module tb_seg_scan_ctrl;
   localparam int DIGITS = 4;
   localparam int DIV    = 8;
   localparam int BF     = 2;
   localparam int FRAME  = DIGITS * DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] value = '0;
   logic [3:0]  dp = '0, blink_mask = '0;
   logic        load = 1'b0, lz_blank = 1'b0;
   logic [2:0]  brightness = 3'd7;
   logic [7:1]  cathodes;
   logic        dp_n, frame_done;
   logic [3:0]  AN;

   seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLINK_FRAMES(BF)) dut (
      .clk(clk), .rst(rst), .value(value), .dp(dp), .blink_mask(blink_mask),
      .load(load), .lz_blank(lz_blank), .brightness(brightness),
      .cathodes(cathodes), .dp_n(dp_n), .AN(AN), .frame_done(frame_done));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   logic [6:0] font [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000};

   // Model: cycle count since reset release plus displayed and pending data.
   int          t;
   logic [15:0] m_sv, m_pv;
   logic [3:0]  m_sd, m_sb, m_pd, m_pb;
   bit          m_pend;
   logic [3:0]  e_an;
   logic [6:0]  e_cath;
   logic        e_dpn, e_fd;

   task automatic model_reset();
      t = 0; m_sv = '0; m_pv = '0; m_sd = '0; m_sb = '0; m_pd = '0; m_pb = '0; m_pend = 0;
   endtask

   task automatic model_step();
      int pc, ix, fr, nib;
      bit ph, blank, lit;
      pc  = t % DIV;
      ix  = (t / DIV) % DIGITS;
      fr  = t / FRAME;
      ph  = ((fr / BF) % 2) == 1;
      nib = int'((m_sv >> (4 * ix)) & 16'hF);
      blank = (m_sb[ix] && ph) ||
              (lz_blank && ix != 0 && (m_sv >> (4 * ix)) == 0 && (m_sd >> ix) == 0);
      lit = (pc * 8) < ((int'(brightness) + 1) * DIV);
      if (lit && !blank) begin
         e_an = ~(4'b0001 << ix);
         e_cath = font[nib];
         e_dpn = ~m_sd[ix];
      end else begin
         e_an = 4'hF; e_cath = 7'h7F; e_dpn = 1'b1;
      end
      e_fd = (t % FRAME) == FRAME - 1;
      if (e_fd && m_pend) begin
         m_sv = m_pv; m_sd = m_pd; m_sb = m_pb; m_pend = 0;
      end
      if (load) begin
         m_pv = value; m_pd = dp; m_pb = blink_mask; m_pend = 1;
      end
      t++;
   endtask

   task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d,
                       input logic [3:0] b);
      load = ld; value = v; dp = d; blink_mask = b;
      model_step();
      @(posedge clk);
      @(negedge clk);
      chk("an", 32'(AN), 32'(e_an));
      chk("cathodes", 32'(cathodes), 32'(e_cath));
      chk("dp_n", 32'(dp_n), 32'(e_dpn));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, value, dp, blink_mask);
   endtask

   task automatic check_blank(input string tag);
      chk({tag, "_an"}, 32'(AN), 32'hF);
      chk({tag, "_cath"}, 32'(cathodes), 32'h7F);
      chk({tag, "_dpn"}, 32'(dp_n), 32'h1);
      chk({tag, "_fd"}, 32'(frame_done), 32'h0);
   endtask

   task automatic mid_reset();
      #2 rst = 1'b1;
      #1 check_blank("rst_mid");
      @(posedge clk);
      @(negedge clk);
      check_blank("rst_hold");
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      check_blank("rst_init");
      @(negedge clk);
      rst = 1'b0;

      step(1'b0, 16'h0, 4'h0, 4'h0);
      chk("first_an", 32'(AN), 32'hE);
      idle(9);
      step(1'b1, 16'h12AF, 4'h0, 4'h0);
      idle(3 * FRAME);

      idle(3);
      step(1'b1, 16'h1111, 4'h0, 4'h0);
      idle(2);
      step(1'b1, 16'h2222, 4'h0, 4'h0);
      idle(2 * FRAME);

      lz_blank = 1'b1;
      step(1'b1, 16'h0050, 4'h0, 4'h0);
      idle(2 * FRAME);
      step(1'b1, 16'h0050, 4'b0100, 4'h0);
      idle(2 * FRAME);
      lz_blank = 1'b0;

      step(1'b1, 16'h1234, 4'h0, 4'b0001);
      idle(6 * FRAME);
      brightness = 3'd3;
      idle(2 * FRAME);
      brightness = 3'd0;
      idle(FRAME);
      brightness = 3'd7;

      while ((t % FRAME) != FRAME - 2) step(1'b0, value, dp, blink_mask);
      step(1'b1, 16'hABCD, 4'h3, 4'h0);
      step(1'b1, 16'h5E7A, 4'h8, 4'h0);
      idle(2 * FRAME + 5);

      mid_reset();
      idle(FRAME);
      step(1'b1, 16'h9C0E, 4'h2, 4'h0);
      idle(FRAME + 3);

      for (int k = 0; k < 1500; k++) begin
         if (k % 100 == 0) begin
            brightness = 3'($urandom_range(0, 7));
            lz_blank = 1'($urandom_range(0, 1));
         end
         if (k == 777) mid_reset();
         if ($urandom_range(0, 15) == 0)
            step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0));
         else
            step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
